// File: rtl/condicionador_botoes.sv
// rtl/condicionador_botoes.sv - two-channel button conditioner: sync, debounce, press pulse, inc auto-repeat
// Channel 0 is adjust (single pulse per press), channel 1 is increment (press plus auto-repeat).
module condicionador_botoes #(
  parameter int DEB_CYCLES    = 16,
  parameter int HOLD_CYCLES   = 64,
  parameter int REPEAT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_ajuste_raw,
  input  logic btn_inc_raw,
  output logic btn_ajuste,
  output logic btn_inc,
  output logic ajuste_nivel,
  output logic inc_nivel
);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] REP_LOAD  = HW'(REPEAT_CYCLES - 1);

  logic [1:0]    w_raw;
  logic [1:0]    r_sync1;
  logic [1:0]    r_sync2;
  logic [1:0]    r_level;
  logic [1:0]    r_pulse;
  logic [DW-1:0] r_deb_cnt [2];
  logic [HW-1:0] r_tmr;
  logic [1:0]    w_diff;
  logic [1:0]    w_accept;
  logic [1:0]    w_rise;
  logic          w_inc_fall;
  logic          w_rep_fire;

  assign w_raw = {btn_inc_raw, btn_ajuste_raw};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // The counter reaching DEB_CYCLES on this edge is the accept condition.
  always_comb begin
    w_diff   = '0;
    w_accept = '0;
    w_rise   = '0;
    for (int c = 0; c < 2; c++) begin
      w_diff[c]   = r_sync2[c] ^ r_level[c];
      w_accept[c] = w_diff[c] && (r_deb_cnt[c] == DEB_LAST);
      w_rise[c]   = w_accept[c] && !r_level[c];
    end
  end

  assign w_inc_fall = w_accept[1] && r_level[1];
  assign w_rep_fire = r_level[1] && !w_inc_fall && (r_tmr == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_level      <= '0;
      r_deb_cnt[0] <= '0;
      r_deb_cnt[1] <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (!w_diff[c] || w_accept[c]) begin
          r_deb_cnt[c] <= '0;
        end else begin
          r_deb_cnt[c] <= r_deb_cnt[c] + 1'b1;
        end
        if (w_accept[c]) begin
          r_level[c] <= ~r_level[c];
        end
      end
    end
  end

  // Down-counter: loaded with the hold delay on press, reloaded with the repeat period on each repeat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tmr <= '0;
    end else if (w_rise[1]) begin
      r_tmr <= HOLD_LOAD;
    end else if (r_level[1] && !w_inc_fall) begin
      if (r_tmr == '0) begin
        r_tmr <= REP_LOAD;
      end else begin
        r_tmr <= r_tmr - 1'b1;
      end
    end else begin
      r_tmr <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pulse <= '0;
    end else begin
      r_pulse[0] <= w_rise[0];
      r_pulse[1] <= w_rise[1] || w_rep_fire;
    end
  end

  assign btn_ajuste   = r_pulse[0];
  assign btn_inc      = r_pulse[1];
  assign ajuste_nivel = r_level[0];
  assign inc_nivel    = r_level[1];
endmodule

// File: tb/tb_condicionador_botoes.sv
// tb/tb_condicionador_botoes.sv - self-checking bench for condicionador_botoes
// Edge n is the n-th rising edge after reset release; outputs are sampled 1 ns after it.
module tb_condicionador_botoes;
  logic clk;
  logic reset;
  logic btn_ajuste_raw;
  logic btn_inc_raw;
  logic btn_ajuste;
  logic btn_inc;
  logic ajuste_nivel;
  logic inc_nivel;

  int errors = 0;
  int checks = 0;
  int q_aj[$];
  int q_inc[$];

  condicionador_botoes dut (
    .clk           (clk),
    .reset         (reset),
    .btn_ajuste_raw(btn_ajuste_raw),
    .btn_inc_raw   (btn_inc_raw),
    .btn_ajuste    (btn_ajuste),
    .btn_inc       (btn_inc),
    .ajuste_nivel  (ajuste_nivel),
    .inc_nivel     (inc_nivel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    int aj_on;   int aj_off;  bit aj_bounce;
    int inc_on;  int inc_off;
    int aj_p;
    int inc_p0;  int inc_p1;  int inc_p2;  int inc_p3;
    int aj_rise; int aj_fall; int inc_rise; int inc_fall;
    int n_edges;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit raw_at(input int on, input int off, input bit bounce, input int n);
    if (on == 0) return 1'b0;
    if (bounce && n <= 30) return (((n - 1) / 5) % 2) == 0;
    return (n >= on) && (n <= off);
  endfunction

  task automatic apply_reset(input bit aj, input bit inc);
    reset = 1'b0;
    btn_ajuste_raw = aj;
    btn_inc_raw = inc;
    #1;
    chk("reset btn_ajuste", btn_ajuste, 0);
    chk("reset btn_inc", btn_inc, 0);
    chk("reset ajuste_nivel", ajuste_nivel, 0);
    chk("reset inc_nivel", inc_nivel, 0);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("reset hold pulses", {30'd0, btn_ajuste, btn_inc}, 0);
      chk("reset hold levels", {30'd0, ajuste_nivel, inc_nivel}, 0);
    end
    reset = 1'b1;
  endtask

  task automatic pulse_sb(input string name, input bit p, input int n, inout int q[$]);
    int e;
    if (p) begin
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(name, n, e);
      end else begin
        chk({name, " unexpected"}, n, 0);
      end
    end
  endtask

  task automatic run_seg(input string tag, input int n_edges,
                         input int aj_on, input int aj_off, input bit aj_b,
                         input int inc_on, input int inc_off,
                         input int aj_rise, input int aj_fall,
                         input int inc_rise, input int inc_fall);
    for (int n = 1; n <= n_edges; n++) begin
      btn_ajuste_raw = raw_at(aj_on, aj_off, aj_b, n);
      btn_inc_raw = raw_at(inc_on, inc_off, 1'b0, n);
      @(posedge clk);
      #1;
      pulse_sb({tag, " btn_ajuste edge"}, btn_ajuste, n, q_aj);
      pulse_sb({tag, " btn_inc edge"}, btn_inc, n, q_inc);
      chk($sformatf("%s ajuste_nivel@%0d", tag, n), ajuste_nivel, int'(n >= aj_rise && n < aj_fall));
      chk($sformatf("%s inc_nivel@%0d", tag, n), inc_nivel, int'(n >= inc_rise && n < inc_fall));
    end
    while (q_aj.size() > 0) chk({tag, " btn_ajuste missing"}, 0, q_aj.pop_front());
    while (q_inc.size() > 0) chk({tag, " btn_inc missing"}, 0, q_inc.pop_front());
  endtask

  initial begin
    reset = 1'b0;
    btn_ajuste_raw = 1'b0;
    btn_inc_raw = 1'b0;

    //             aj_on off  bnc inc_on off  ajp incp0..3          ajr ajf  incr incf  N
    tbl[0] = '{0,   0,   0,  1,   40,  0,  18, 0,  0,  0,   0,  0,   18,  58,  80};
    tbl[1] = '{0,   0,   0,  1,   110, 0,  18, 82, 98, 114, 0,  0,   18,  128, 160};
    tbl[2] = '{1,   120, 0,  0,   0,   18, 0,  0,  0,  0,   18, 138, 0,   0,   160};
    tbl[3] = '{1,   30,  0,  1,   30,  18, 18, 0,  0,  0,   18, 48,  18,  48,  70};
    tbl[4] = '{0,   0,   0,  1,   15,  0,  0,  0,  0,  0,   0,  0,   0,   0,   50};
    tbl[5] = '{0,   0,   0,  1,   16,  0,  18, 0,  0,  0,   0,  0,   18,  34,  50};
    tbl[6] = '{1,   100, 1,  0,   0,   48, 0,  0,  0,  0,   48, 118, 0,   0,   140};
    tbl[7] = '{0,   0,   0,  1,   112, 0,  18, 82, 98, 114, 0,  0,   18,  130, 150};

    for (int i = 0; i < 8; i++) begin
      apply_reset(1'b0, 1'b0);
      if (tbl[i].aj_p != 0) q_aj.push_back(tbl[i].aj_p);
      if (tbl[i].inc_p0 != 0) q_inc.push_back(tbl[i].inc_p0);
      if (tbl[i].inc_p1 != 0) q_inc.push_back(tbl[i].inc_p1);
      if (tbl[i].inc_p2 != 0) q_inc.push_back(tbl[i].inc_p2);
      if (tbl[i].inc_p3 != 0) q_inc.push_back(tbl[i].inc_p3);
      run_seg($sformatf("vec%0d", i), tbl[i].n_edges,
              tbl[i].aj_on, tbl[i].aj_off, tbl[i].aj_bounce,
              tbl[i].inc_on, tbl[i].inc_off,
              tbl[i].aj_rise, tbl[i].aj_fall, tbl[i].inc_rise, tbl[i].inc_fall);
    end

    // Reset mid-hold with the inc button already pressed across release.
    apply_reset(1'b0, 1'b1);
    q_inc.push_back(18);
    run_seg("hold_a", 50, 0, 0, 1'b0, 1, 9999, 0, 0, 18, 9999);
    apply_reset(1'b0, 1'b1);
    q_inc.push_back(18);
    run_seg("hold_b", 40, 0, 0, 1'b0, 1, 9999, 0, 0, 18, 9999);

    // Reset mid-debounce, then released with the button up: nothing may come out.
    apply_reset(1'b0, 1'b0);
    run_seg("deb_a", 10, 1, 9999, 1'b0, 1, 9999, 0, 0, 0, 0);
    apply_reset(1'b0, 1'b0);
    run_seg("deb_b", 40, 0, 0, 1'b0, 0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/condicionador_botoes.md
CONDICIONADOR_BOTOES -- requirements
Module: condicionador_botoes

Interface
REQ-001 The block SHALL expose parameter DEB_CYCLES, default 16, meaning consecutive stable cycles required to accept a level change (legal range 2 or more).
REQ-002 The block SHALL expose parameter HOLD_CYCLES, default 64, meaning cycles from the initial inc pulse to the first auto-repeat pulse (legal range REPEAT_CYCLES or more).
REQ-003 The block SHALL expose parameter REPEAT_CYCLES, default 16, meaning cycles between successive auto-repeat pulses (legal range 1 or more).
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset: clk  input  1  system clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 btn_ajuste_raw  input  1  raw, unsynchronized, bouncing adjust button (high = pressed).
REQ-007 btn_inc_raw  input  1  raw, unsynchronized, bouncing increment button (high = pressed).
REQ-008 btn_ajuste  output  1  one-cycle press pulse, adjust channel.
REQ-009 btn_inc  output  1  one-cycle press/auto-repeat pulse, increment channel.
REQ-010 ajuste_nivel  output  1  debounced level, adjust channel.
REQ-011 inc_nivel  output  1  debounced level, increment channel.

Function
REQ-012 Each raw input SHALL pass through a 2-flop synchronizer; no other logic SHALL sample the raw inputs.
REQ-013 Per channel, a debounce counter SHALL increment each edge on which the synchronized input differs from the debounced level, and SHALL clear on any edge where they agree.
REQ-014 On the edge where the counter reaches DEB_CYCLES, the debounced level SHALL toggle and the counter SHALL clear.
REQ-015 Latency SHALL be as follows: raw stable before edge 1 gives a debounced change and pulse at edge DEB_CYCLES+2, which is edge 18 at defaults.
REQ-016 A press pulse SHALL be registered high for exactly one cycle on the edge the debounced level rises.
REQ-017 The falling debounced level SHALL produce no pulse.
REQ-018 Any glitch shorter than DEB_CYCLES stable cycles SHALL produce no level change and no pulse.
REQ-019 The adjust channel SHALL emit exactly one pulse per accepted press, with no auto-repeat.
REQ-020 Inc auto-repeat SHALL work as follows: if the initial pulse is at edge P and the level is held, additional pulses SHALL occur at P+HOLD_CYCLES, then every REPEAT_CYCLES thereafter, until the level falls.
REQ-021 A falling debounced inc level SHALL stop auto-repeat on that same edge; no pulse SHALL occur on or after it.
REQ-022 Hold and repeat counters SHALL be sized ceil(log2(max+1)) and SHALL never wrap; they hold at their reload point.
REQ-023 The channels SHALL be fully independent; both pulses MAY assert in the same cycle and neither SHALL be suppressed or delayed.
REQ-024 The outputs SHALL be driven directly from flops, with no combinational path from input to output.

Reset
REQ-025 While reset is low, all synchronizer flops, counters, levels and pulses SHALL be 0, asynchronously.
REQ-026 After reset releases with a raw input already high, the channel SHALL debounce normally and pulse at DEB_CYCLES+2 edges after release.
REQ-027 Reset asserted mid-hold or mid-debounce SHALL discard all in-progress counts; no pulse SHALL be emitted for the interrupted activity.

Verification
REQ-028 Clean press: btn_inc_raw high from edge 1 for 40 cycles, then low -> btn_inc is one pulse at edge 18, inc_nivel rises at 18, and no pulse occurs on release.
REQ-029 Bounce: btn_ajuste_raw toggles every 5 cycles for 30 cycles, then is held high -> exactly one btn_ajuste pulse, 18 edges after the final settle.
REQ-030 Auto-repeat: btn_inc_raw high edges 1-110 -> btn_inc pulses at 18, 82, 98 and 114; inc_nivel falls at 128; there are no further pulses.
REQ-031 No repeat on adjust: btn_ajuste_raw high for 120 cycles -> a single pulse at 18, with ajuste_nivel high from 18 until release.
REQ-032 Reset mid-hold: btn_inc_raw held high, reset low at edge 50 for 3 cycles -> outputs 0 immediately; one pulse 18 edges after release.
REQ-033 Simultaneous press: both raw inputs rise before edge 1 -> btn_ajuste and btn_inc both pulse at edge 18.
